// File: rtl/uart_rx_if.sv
// Read side of the UART receiver: FIFO head, handshake, status and event
// pulses shared between the receiver and the UART register block.
interface uart_rx_if;
  logic [7:0] rxdata;
  logic       rxdata_valid;
  logic       rxdata_ready;
  logic       rxfifo_full;
  logic       rxfifo_empty;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rxdata, rxdata_valid, rxfifo_full, rxfifo_empty,
    output parity_err, frame_err, overrun,
    input  rxdata_ready
  );

  modport slave (
    input  rxdata, rxdata_valid, rxfifo_full, rxfifo_empty,
    input  parity_err, frame_err, overrun,
    output rxdata_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receive path: 2-FF synchronizer, oversampled frame recovery
// (start, 8 data bits LSB first, optional even parity, stop), a show-ahead
// RX FIFO, registered RTS flow control and one-cycle event pulses.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RTS_LEVEL  = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      rx,
  input  logic      parity_en,
  input  logic      flush,
  output logic      rx_rts_n,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]  MID_BIT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] RTS_CNT   = FCNT_W'(RTS_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

  logic             sync1_q, rxs_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_bad_q, par_bad_d;
  logic             push_s, frame_err_s, parity_hit_s;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic              pop_s, full_s, wr_en_s, overrun_s;

  logic              parity_err_q, frame_err_q, overrun_q, rts_n_q;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Next state, bit sampling at mid-bit ticks, and push / error decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    push_s       = 1'b0;
    frame_err_s  = 1'b0;
    parity_hit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick) begin
          if (cnt_q == MID_START) begin
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              cnt_d     = '0;
              bitcnt_d  = 3'd0;
              par_bad_d = 1'b0;
              state_d   = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q == MID_BIT) begin
            shreg_d[bitcnt_q] = rxs_q;
            cnt_d             = '0;
            bitcnt_d          = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              // parity_en is only looked at here, so later changes cannot
              // disturb the frame in flight.
              state_d = parity_en ? S_PARITY : S_STOP;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (cnt_q == MID_BIT) begin
            par_bad_d = rxs_q ^ parity8(shreg_q);
            cnt_d     = '0;
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (cnt_q == MID_BIT) begin
            cnt_d = '0;
            if (rxs_q) begin
              push_s       = 1'b1;
              parity_hit_s = par_bad_q;
              state_d      = S_IDLE;
            end else begin
              frame_err_s = 1'b1;
              state_d     = S_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start.
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head pops.
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    pop_s     = (count_q != '0) && bus.rxdata_ready;
    wr_en_s   = push_s && (!full_s || pop_s);
    overrun_s = push_s && full_s && !pop_s;
  end

  // FIFO storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Event pulses and RTS, registered so they appear the cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rts_n_q      <= 1'b1;
    end else begin
      parity_err_q <= parity_hit_s;
      frame_err_q  <= frame_err_s;
      overrun_q    <= overrun_s;
      rts_n_q      <= (count_q >= RTS_CNT);
    end
  end

  assign rx_rts_n         = rts_n_q;
  assign bus.rxdata       = mem_q[rd_ptr_q];
  assign bus.rxdata_valid = (count_q != '0);
  assign bus.rxfifo_empty = (count_q == '0);
  assign bus.rxfifo_full  = (count_q == FULL_CNT);
  assign bus.parity_err   = parity_err_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.overrun      = overrun_q;

endmodule
